if_prefetch: RTL and testbench



---
 rtl/if_prefetch_pkg.sv | 15 +
 rtl/if_queue.sv | 56 +++++
 rtl/if_prefetch.sv | 147 ++++++++++++++
 tb/tb_if_prefetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// rtl/if_prefetch_pkg.sv - shared types and constants for the instruction-fetch stage
package if_prefetch_pkg;

  typedef logic [31:0] MemAddrBus;
  typedef logic [31:0] InstBus;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  localparam int INST_STEP = 4;

endpackage

// File: rtl/if_queue.sv
// rtl/if_queue.sv - generic circular FIFO with push, pop, flush, count and full/empty
module if_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(DEPTH));
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  // A pop frees the slot the simultaneous push lands in, so push-on-full is legal then.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch stage with prefetch queue and redirect flush
// Optional IF_BYPASS_EN: forward a response straight to ID when the queue is empty.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = $bits(MemAddrBus),
  parameter int                    INST_WIDTH = $bits(InstBus),
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  br_wait,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_ready,
  input  logic [INST_WIDTH-1:0] ram_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  stall_if
);

  localparam int                    CNT_W = $clog2(DEPTH) + 1;
  localparam int                    QW    = ADDR_WIDTH + INST_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(INST_STEP);

  if_state_e             r_state;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_read;

  logic [QW-1:0]         w_q_dout;
  logic [CNT_W-1:0]      w_q_count;
  logic                  w_q_full;
  logic                  w_q_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic [CNT_W-1:0]      w_occ_next;
  logic                  w_issue;

`ifdef IF_BYPASS_EN
  assign w_bypass = w_q_empty && (r_state == IF_WAIT) && ram_ready && !redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop      = !w_q_empty && inst_ready && !redirect;
  // A response consumed directly through the bypass never occupies a slot.
  assign w_push     = (r_state == IF_WAIT) && ram_ready && !redirect &&
                      !(w_bypass && inst_ready) && (!w_q_full || w_pop);
  assign w_occ_next = w_q_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_issue    = !br_wait && !redirect && (w_occ_next < CNT_W'(DEPTH));

  if_queue #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   ({r_ram_addr, ram_data}),
    .dout  (w_q_dout),
    .count (w_q_count),
    .full  (w_q_full),
    .empty (w_q_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IF_IDLE;
      r_fetch_pc <= RESET_PC;
      r_ram_read <= 1'b0;
      r_ram_addr <= '0;
    end else begin
      if (redirect) r_fetch_pc <= redirect_pc;
      case (r_state)
        IF_IDLE: begin
          if (w_issue) begin
            r_state    <= IF_WAIT;
            r_ram_read <= 1'b1;
            r_ram_addr <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + STEP;
          end
        end
        IF_WAIT: begin
          // Memory cannot abort, so a redirect before the response keeps the request up.
          if (redirect) begin
            if (ram_ready) begin
              r_state    <= IF_IDLE;
              r_ram_read <= 1'b0;
            end else begin
              r_state <= IF_DISCARD;
            end
          end else if (ram_ready) begin
            if (w_issue) begin
              r_ram_addr <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + STEP;
            end else begin
              r_state    <= IF_IDLE;
              r_ram_read <= 1'b0;
            end
          end
        end
        IF_DISCARD: begin
          if (ram_ready) begin
            r_state    <= IF_IDLE;
            r_ram_read <= 1'b0;
          end
        end
        default: begin
          r_state    <= IF_IDLE;
          r_ram_read <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    inst_valid = 1'b0;
    pc_o       = '0;
    inst_o     = '0;
    if (!w_q_empty) begin
      inst_valid = 1'b1;
      pc_o       = w_q_dout[QW-1:INST_WIDTH];
      inst_o     = w_q_dout[INST_WIDTH-1:0];
    end
`ifdef IF_BYPASS_EN
    else if (w_bypass) begin
      inst_valid = 1'b1;
      pc_o       = r_ram_addr;
      inst_o     = ram_data;
    end
`endif
  end

  assign ram_read = r_ram_read;
  assign ram_addr = r_ram_addr;
  assign stall_if = !inst_valid;

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - self-checking bench for if_prefetch (honours IF_BYPASS_EN)
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        br_wait = 1'b0;
  logic        ram_read;
  logic [31:0] ram_addr;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stall_if;

  int n_checks = 0;
  int n_pass = 0;

  if_prefetch dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .br_wait     (br_wait),
    .ram_read    (ram_read),
    .ram_addr    (ram_addr),
    .ram_ready   (ram_ready),
    .ram_data    (ram_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .stall_if    (stall_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Memory responder: strobes ram_ready for one cycle after a programmable latency.
  int mem_lat = 2;
  int cur_lat = 2;
  int mem_cnt = 0;
  bit mem_rand = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      ram_ready = 1'b0;
      mem_cnt = 0;
    end else if (ram_ready) begin
      ram_ready = 1'b0;
      mem_cnt = 0;
    end else if (ram_read) begin
      if (mem_cnt == 0) cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      mem_cnt++;
      if (mem_cnt >= cur_lat) begin
        ram_ready = 1'b1;
        ram_data = memf(ram_addr);
      end
    end
  end

  // Reference model: ID must see an unbroken pc stream stepping by 4 from the
  // reset PC or from the latest redirect target, each with its memory word.
  logic [31:0] exp_pc = '0;
  logic [31:0] last_pc = '0;
  int          accepts = 0;
  logic [31:0] win_lo = '0;
  logic [31:0] win_hi = '0;
  int          win_resp = 0;
  always @(negedge clk) begin
    #3;
    if (!reset) begin
      exp_pc = 32'h0;
    end else begin
      check_eq("stall_if", 32'(stall_if), 32'(!inst_valid));
      if (!inst_valid) begin
        check_eq("pc_o_idle", pc_o, 32'h0);
        check_eq("inst_o_idle", inst_o, 32'h0);
      end
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (inst_valid && inst_ready) begin
        check_eq("id_pc", pc_o, exp_pc);
        check_eq("id_inst", inst_o, memf(exp_pc));
        last_pc = pc_o;
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (ram_ready && !redirect && ram_addr >= win_lo && ram_addr < win_hi) win_resp++;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc = pc;
    redirect = 1'b1;
    cyc();
    redirect = 1'b0;
  endtask

  typedef struct {
    logic [31:0] start_pc;
    int          lat;
    int          n;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int          k;
    int          a0;
    int          resp;
    bit          seen_resp;
    bit          read_after;
    logic [31:0] old_addr;

    vecs[0] = '{32'h0000_1000, 1, 3, 32'h0000_1008};
    vecs[1] = '{32'h0000_2000, 3, 4, 32'h0000_200C};
    vecs[2] = '{32'hFFFF_FFF8, 2, 4, 32'h0000_0004};
    vecs[3] = '{32'h0000_0040, 4, 2, 32'h0000_0044};

    repeat (3) cyc();
    check_eq("rst_ram_read", 32'(ram_read), 32'h0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'h0);
    check_eq("rst_pc_o", pc_o, 32'h0);
    check_eq("rst_inst_o", inst_o, 32'h0);
    check_eq("rst_stall_if", 32'(stall_if), 32'h1);

    mem_lat = 2;
    inst_ready = 1'b1;
    reset = 1'b1;
    cyc();
    check_eq("first_req", 32'(ram_read), 32'h1);
    check_eq("first_addr", ram_addr, 32'h0);
    for (k = 0; k < 16 && accepts < 4; k++) cyc();
    check_eq("stream_4_in_time", 32'(accepts >= 4), 32'h1);
    check_eq("stream_last_pc", last_pc, 32'hC);

    for (int i = 0; i < 4; i++) begin
      mem_lat = vecs[i].lat;
      inst_ready = 1'b1;
      a0 = accepts;
      do_redirect(vecs[i].start_pc);
      for (k = 0; k < 100 && accepts - a0 < vecs[i].n; k++) cyc();
      inst_ready = 1'b0;
      check_eq("tbl_count", 32'(accepts - a0), 32'(vecs[i].n));
      check_eq("tbl_last_pc", last_pc, vecs[i].exp_last);
    end

    // Stalled ID: the queue fills to DEPTH, then one pop buys exactly one request.
    inst_ready = 1'b0;
    mem_lat = 2;
    win_lo = 32'h200;
    win_hi = 32'h300;
    win_resp = 0;
    do_redirect(32'h200);
    repeat (40) cyc();
    check_eq("full_pushes", 32'(win_resp), 32'd4);
    check_eq("full_no_read", 32'(ram_read), 32'h0);
    check_eq("full_valid", 32'(inst_valid), 32'h1);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    repeat (30) cyc();
    check_eq("pop_one_req", 32'(win_resp), 32'd5);
    check_eq("pop_one_idle", 32'(ram_read), 32'h0);
    check_eq("pop_one_pc", last_pc, 32'h200);

    // Redirect while a request is outstanding: queue flushes, late data is dropped.
    mem_lat = 3;
    win_lo = 32'h300;
    win_hi = 32'h400;
    do_redirect(32'h300);
    for (k = 0; k < 60 && !(inst_valid && ram_read && !ram_ready); k++) cyc();
    check_eq("wait_found", 32'(inst_valid && ram_read && !ram_ready), 32'h1);
    old_addr = ram_addr;
    redirect_pc = 32'h100;
    redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    check_eq("flush_empty", 32'(inst_valid), 32'h0);
    check_eq("discard_held_addr", ram_addr, old_addr);
    for (k = 0; k < 20 && ram_read; k++) cyc();
    for (k = 0; k < 20 && !ram_read; k++) cyc();
    check_eq("after_discard_addr", ram_addr, 32'h100);
    inst_ready = 1'b1;
    a0 = accepts;
    for (k = 0; k < 30 && accepts == a0; k++) cyc();
    inst_ready = 1'b0;
    check_eq("after_discard_pc", last_pc, 32'h100);

    // Redirect in the same cycle as ram_ready.
    mem_lat = 2;
    do_redirect(32'h400);
    for (k = 0; k < 60 && !(ram_ready && ram_addr == 32'h400); k++) cyc();
    check_eq("rdy_seen", 32'(ram_ready && ram_addr == 32'h400), 32'h1);
    redirect_pc = 32'h500;
    redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    check_eq("drop_empty", 32'(inst_valid), 32'h0);
    check_eq("drop_idle", 32'(ram_read), 32'h0);
    for (k = 0; k < 5 && !ram_read; k++) cyc();
    check_eq("drop_next_addr", ram_addr, 32'h500);
    inst_ready = 1'b1;
    a0 = accepts;
    for (k = 0; k < 30 && accepts == a0; k++) cyc();
    inst_ready = 1'b0;
    check_eq("drop_next_pc", last_pc, 32'h500);

    // br_wait: outstanding request completes and is queued, nothing new issues.
    do_redirect(32'h600);
    for (k = 0; k < 60 && !(ram_read && !ram_ready && ram_addr == 32'h600); k++) cyc();
    check_eq("brw_req_seen", ram_addr, 32'h600);
    br_wait = 1'b1;
    resp = 0;
    seen_resp = 1'b0;
    read_after = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (seen_resp && ram_read) read_after = 1'b1;
      if (ram_ready) begin
        resp++;
        seen_resp = 1'b1;
      end
    end
    check_eq("brw_resp", 32'(resp), 32'd1);
    check_eq("brw_no_new_req", 32'(read_after), 32'h0);
    check_eq("brw_queued_valid", 32'(inst_valid), 32'h1);
    check_eq("brw_queued_pc", pc_o, 32'h600);
    br_wait = 1'b0;
    for (k = 0; k < 4 && !ram_read; k++) cyc();
    check_eq("brw_release_addr", ram_addr, 32'h604);

    // Empty queue, response arriving: bypass presents it in the same cycle.
    inst_ready = 1'b1;
    do_redirect(32'h700);
    for (k = 0; k < 30 && !(ram_ready && ram_addr == 32'h700); k++) cyc();
    check_eq("byp_rdy_seen", 32'(ram_ready && ram_addr == 32'h700), 32'h1);
`ifdef IF_BYPASS_EN
    check_eq("byp_valid", 32'(inst_valid), 32'h1);
    check_eq("byp_pc", pc_o, 32'h700);
`else
    check_eq("nobyp_valid", 32'(inst_valid), 32'h0);
`endif

    mem_rand = 1'b1;
    a0 = accepts;
    for (int i = 0; i < 2000; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      br_wait = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect = 1'b1;
        redirect_pc = $urandom & 32'hFFFF_FFFC;
      end else begin
        redirect = 1'b0;
      end
      cyc();
    end
    redirect = 1'b0;
    br_wait = 1'b0;
    check_eq("rand_progress", 32'(accepts - a0 >= 100), 32'h1);

    // Reset in the middle of traffic: restart from the reset PC.
    reset = 1'b0;
    cyc();
    check_eq("midrst_read", 32'(ram_read), 32'h0);
    check_eq("midrst_valid", 32'(inst_valid), 32'h0);
    cyc();
    inst_ready = 1'b1;
    reset = 1'b1;
    a0 = accepts;
    for (k = 0; k < 30 && accepts == a0; k++) cyc();
    check_eq("midrst_first_pc", last_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
